// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e    : converter FSM states
//   BCD_DIGITS : number of packed BCD digits in the result
//   BCD_MAX    : largest value representable in BCD_DIGITS decimal digits
//   BCD_SAT    : saturated result used when overflow handling is built in
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int          BCD_DIGITS = 8;
    localparam logic [31:0] BCD_MAX    = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a requester and the binary-to-BCD converter.
//   start : request a conversion (requester -> converter)
//   bin   : unsigned binary value, BIN_WIDTH bits (requester -> converter)
//   busy  : converter not idle (converter -> requester)
//   done  : one-cycle result-valid pulse (converter -> requester)
//   bcd   : eight packed BCD digits, units in [3:0] (converter -> requester)
//   ovf   : overflow flag, updates with bcd (converter -> requester)
// Modports: master = requester side, slave = converter side.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH = 27
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin;
    logic                 busy;
    logic                 done;
    logic [31:0]          bcd;
    logic                 ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   d_i : 4-bit digit before correction
//   d_o : 4-bit digit after correction (wraps, no carry out)
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One bit is consumed per
// cycle, so a conversion takes BIN_WIDTH cycles plus one DONE cycle.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin2bcd_seq_if slave modport (start/bin in, busy/done/bcd/ovf out)
// Optional macro BIN2BCD_OVF_EN: saturate to 9999_9999 and raise ovf when the
// captured input exceeds 99_999_999 (comparator only when BIN_WIDTH >= 27).
// Without it ovf is tied low and the result is bin mod 10^8.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; bin captured on the accepting edge
//   SHIFT | one add-3/shift step per cycle, counter runs BIN_WIDTH..1
//   DONE  | done pulse, bcd valid; always returns to IDLE
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int SW = 4 * BCD_DIGITS;

    state_e               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]        scratch_q, scratch_d;
    logic [SW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [SW-1:0]        adj;
    logic [SW+BIN_WIDTH-1:0] shifted;
    logic                 accept;
    logic                 last_step;
    logic                 sat;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scratch_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    // The bit leaving digit 7 falls off the top here: result is modulo 10^8.
    assign shifted   = {adj, shift_q} << 1;
    assign accept    = (state_q == IDLE) && bus.start;
    assign last_step = (state_q == SHIFT) && (cnt_q == CW'(1));

`ifdef BIN2BCD_OVF_EN
    logic bin_ovf;
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;

    if (BIN_WIDTH >= 27) begin : g_cmp
        logic [31:0] bin_ext;
        assign bin_ext = 32'(bus.bin);
        assign bin_ovf = (bin_ext > BCD_MAX);
    end else begin : g_no_cmp
        assign bin_ovf = 1'b0;
    end

    always_comb begin
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        if (accept) begin
            ovf_pend_d = bin_ovf;
        end
        if (last_step) begin
            ovf_d = ovf_pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign sat     = ovf_pend_q;
    assign bus.ovf = ovf_q;
`else
    assign sat     = 1'b0;
    assign bus.ovf = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = CW'(BIN_WIDTH);
                end
            end
            SHIFT: begin
                scratch_d = shifted[SW+BIN_WIDTH-1:BIN_WIDTH];
                shift_d   = shifted[BIN_WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (last_step) begin
                    state_d = DONE;
                    // Result register takes the post-shift value so bcd
                    // never exposes a partially converted number.
                    bcd_d   = sat ? BCD_SAT : shifted[SW+BIN_WIDTH-1:BIN_WIDTH];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.bcd  = bcd_q;

endmodule
